// File: rtl/line_interp.sv
// line_interp: stroke rasteriser feeding write_buffer (vga_clk domain).
// Turns sparse camera samples into a continuous Bresenham line from the
// previous sample to the current one, emitted one point per valid/ready
// handshake.
// Optional build macro: LINE_INTERP_STATS_EN adds drop_count / point_count.
module line_interp #(
    parameter int unsigned X_W   = 10,
    parameter int unsigned Y_W   = 10,
    parameter int unsigned X_MAX = 639,
    parameter int unsigned Y_MAX = 479
) (
    input  logic           clk,
    input  logic           reset,
    input  logic [X_W-1:0] cam_x_in,
    input  logic [Y_W-1:0] cam_y_in,
    input  logic           cam_valid,
    input  logic           pen_down,
    output logic [X_W-1:0] out_x,
    output logic [Y_W-1:0] out_y,
    output logic           out_valid,
    input  logic           out_ready,
    output logic           busy
`ifdef LINE_INTERP_STATS_EN
    ,
    output logic [15:0]    drop_count,
    output logic [15:0]    point_count
`endif
);

    // Error term width: wide enough for 2*err of the largest possible line.
    localparam int unsigned EW = ((X_W > Y_W) ? X_W : Y_W) + 2;

    typedef enum logic [2:0] {StIdle, StSingle, StSetup, StStep, StHold} state_e;

    state_e                r_state;
    // Pending slot, plus a pen-down sample parked behind a pending pen-up.
    logic                  r_pv, r_pp, r_hv;
    logic [X_W-1:0]        r_px, r_hx;
    logic [Y_W-1:0]        r_py, r_hy;
    // Line state.
    logic                  r_have_prev, r_sxn, r_syn;
    logic [X_W-1:0]        r_prev_x, r_tx, r_cx;
    logic [Y_W-1:0]        r_prev_y, r_ty, r_cy;
    logic signed [EW-1:0]  r_dx, r_dy, r_err;

    logic [X_W-1:0]        w_cx, w_px_d, w_hx_d, w_bx, w_nx;
    logic [Y_W-1:0]        w_cy, w_py_d, w_hy_d, w_by, w_ny;
    logic                  w_consume, w_bv, w_bp, w_bhv, w_drop;
    logic                  w_pv_d, w_pp_d, w_hv_d;
    logic signed [EW-1:0]  w_x0e, w_x1e, w_y0e, w_y1e, w_dx_s, w_dy_s, w_err0;
    logic signed [EW-1:0]  w_ex, w_ey, w_err_n;
    logic signed [EW:0]    w_e2, w_dxe, w_dye;
    logic                  w_stx, w_sty, w_same, w_at_end;

    assign w_cx      = (cam_x_in > X_W'(X_MAX)) ? X_W'(X_MAX) : cam_x_in;
    assign w_cy      = (cam_y_in > Y_W'(Y_MAX)) ? Y_W'(Y_MAX) : cam_y_in;
    assign w_consume = (r_state == StIdle) && r_pv;
    assign busy      = (r_state != StIdle) || r_pv;

    // Next pending-slot contents: consume first, then land any new sample (latest wins).
    always_comb begin
        w_bv   = r_pv;
        w_bx   = r_px;
        w_by   = r_py;
        w_bp   = r_pp;
        w_bhv  = r_hv;
        if (w_consume) begin
            w_bv  = r_hv;
            w_bx  = r_hx;
            w_by  = r_hy;
            w_bp  = 1'b1;
            w_bhv = 1'b0;
        end
        w_pv_d = w_bv;
        w_px_d = w_bx;
        w_py_d = w_by;
        w_pp_d = w_bp;
        w_hv_d = w_bhv;
        w_hx_d = r_hx;
        w_hy_d = r_hy;
        w_drop = 1'b0;
        if (cam_valid) begin
            if (w_bv && !w_bp && pen_down) begin
                // A pending pen-up must not be lost; queue the pen-down behind it.
                w_hv_d = 1'b1;
                w_hx_d = w_cx;
                w_hy_d = w_cy;
                w_drop = w_bhv;
            end else begin
                w_pv_d = 1'b1;
                w_px_d = w_cx;
                w_py_d = w_cy;
                w_pp_d = pen_down;
                w_hv_d = 1'b0;
                w_drop = w_bv;
            end
        end
    end

    // Pending sample registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_pv <= 1'b0;
            r_pp <= 1'b0;
            r_px <= '0;
            r_py <= '0;
            r_hv <= 1'b0;
            r_hx <= '0;
            r_hy <= '0;
        end else begin
            r_pv <= w_pv_d;
            r_pp <= w_pp_d;
            r_px <= w_px_d;
            r_py <= w_py_d;
            r_hv <= w_hv_d;
            r_hx <= w_hx_d;
            r_hy <= w_hy_d;
        end
    end

    // Line setup and Bresenham step arithmetic (both updates use the pre-step err).
    always_comb begin
        w_x0e   = $signed({{(EW-X_W){1'b0}}, r_prev_x});
        w_x1e   = $signed({{(EW-X_W){1'b0}}, r_tx});
        w_y0e   = $signed({{(EW-Y_W){1'b0}}, r_prev_y});
        w_y1e   = $signed({{(EW-Y_W){1'b0}}, r_ty});
        w_dx_s  = (r_tx >= r_prev_x) ? (w_x1e - w_x0e) : (w_x0e - w_x1e);
        w_dy_s  = (r_ty >= r_prev_y) ? (w_y0e - w_y1e) : (w_y1e - w_y0e);
        w_err0  = w_dx_s + w_dy_s;
        w_same  = (r_tx == r_prev_x) && (r_ty == r_prev_y);
        w_e2    = $signed({r_err, 1'b0});
        w_dxe   = $signed({r_dx[EW-1], r_dx});
        w_dye   = $signed({r_dy[EW-1], r_dy});
        w_stx   = (w_e2 >= w_dye);
        w_sty   = (w_e2 <= w_dxe);
        w_ex    = w_stx ? r_dy : '0;
        w_ey    = w_sty ? r_dx : '0;
        w_err_n = r_err + w_ex + w_ey;
        w_nx    = r_cx;
        w_ny    = r_cy;
        if (w_stx) w_nx = r_sxn ? (r_cx - X_W'(1)) : (r_cx + X_W'(1));
        if (w_sty) w_ny = r_syn ? (r_cy - Y_W'(1)) : (r_cy + Y_W'(1));
        w_at_end = (r_cx == r_tx) && (r_cy == r_ty);
    end

    // Main FSM with registered point outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= StIdle;
            r_have_prev <= 1'b0;
            r_prev_x    <= '0;
            r_prev_y    <= '0;
            r_tx        <= '0;
            r_ty        <= '0;
            r_cx        <= '0;
            r_cy        <= '0;
            r_sxn       <= 1'b0;
            r_syn       <= 1'b0;
            r_dx        <= '0;
            r_dy        <= '0;
            r_err       <= '0;
            out_x       <= '0;
            out_y       <= '0;
            out_valid   <= 1'b0;
        end else begin
            unique case (r_state)
                StIdle: begin
                    if (r_pv) begin
                        if (!r_pp) begin
                            r_have_prev <= 1'b0;
                        end else if (!r_have_prev) begin
                            r_cx      <= r_px;
                            r_cy      <= r_py;
                            out_x     <= r_px;
                            out_y     <= r_py;
                            out_valid <= 1'b1;
                            r_state   <= StSingle;
                        end else begin
                            r_tx    <= r_px;
                            r_ty    <= r_py;
                            r_state <= StSetup;
                        end
                    end
                end
                StSingle: begin
                    if (out_ready) begin
                        out_valid   <= 1'b0;
                        r_prev_x    <= r_cx;
                        r_prev_y    <= r_cy;
                        r_have_prev <= 1'b1;
                        r_state     <= StIdle;
                    end
                end
                StSetup: begin
                    r_dx    <= w_dx_s;
                    r_dy    <= w_dy_s;
                    r_err   <= w_err0;
                    r_sxn   <= (r_tx < r_prev_x);
                    r_syn   <= (r_ty < r_prev_y);
                    r_cx    <= r_prev_x;
                    r_cy    <= r_prev_y;
                    r_state <= w_same ? StIdle : StStep;
                end
                StStep: begin
                    r_cx      <= w_nx;
                    r_cy      <= w_ny;
                    out_x     <= w_nx;
                    out_y     <= w_ny;
                    r_err     <= w_err_n;
                    out_valid <= 1'b1;
                    r_state   <= StHold;
                end
                StHold: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        if (w_at_end) begin
                            r_prev_x <= r_tx;
                            r_prev_y <= r_ty;
                            r_state  <= StIdle;
                        end else begin
                            r_state <= StStep;
                        end
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

`ifdef LINE_INTERP_STATS_EN
    // Statistics: saturating drop counter, wrapping transfer counter.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            drop_count  <= '0;
            point_count <= '0;
        end else begin
            if (w_drop && (drop_count != 16'hFFFF)) drop_count <= drop_count + 16'd1;
            if (out_valid && out_ready) point_count <= point_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_line_interp.sv
// Directed bench for line_interp: hand-computed point sequences, clipping,
// pen-up, backpressure, overwrite of pending samples and mid-line reset.
module tb_line_interp;

    typedef logic [19:0] pt_t;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [9:0] cam_x_in = '0;
    logic [9:0] cam_y_in = '0;
    logic       cam_valid = 1'b0;
    logic       pen_down = 1'b0;
    logic [9:0] out_x;
    logic [9:0] out_y;
    logic       out_valid;
    logic       out_ready = 1'b1;
    logic       busy;
`ifdef LINE_INTERP_STATS_EN
    logic [15:0] drop_count;
    logic [15:0] point_count;
`endif

    pt_t q[$];
    int  n_vec = 0;
    int  n_err = 0;
    int  n_xfer = 0;

    line_interp dut (
        .clk       (clk),
        .reset     (reset),
        .cam_x_in  (cam_x_in),
        .cam_y_in  (cam_y_in),
        .cam_valid (cam_valid),
        .pen_down  (pen_down),
        .out_x     (out_x),
        .out_y     (out_y),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .busy      (busy)
`ifdef LINE_INTERP_STATS_EN
        ,
        .drop_count  (drop_count),
        .point_count (point_count)
`endif
    );

    always #5 clk = ~clk;

    // A point seen valid&ready at negedge transfers on the following posedge.
    always @(negedge clk) begin
        if (reset && out_valid && out_ready) begin
            q.push_back({out_x, out_y});
            n_xfer++;
        end
    end

    function automatic pt_t pt(input int x, input int y);
        return {10'(x), 10'(y)};
    endfunction

    function automatic pt_t q_at(input int i);
        if (i < 0 || i >= q.size()) return '1;
        return q[i];
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic send(input int x, input int y, input logic p);
        @(posedge clk);
        #1;
        cam_x_in  = 10'(x);
        cam_y_in  = 10'(y);
        pen_down  = p;
        cam_valid = 1'b1;
        @(posedge clk);
        #1;
        cam_valid = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int c;
        c = 0;
        do begin
            @(negedge clk);
            c++;
        end while (busy && c < 20000);
        check_eq({tag, "_idle"}, 32'(busy), 32'd0);
    endtask

    task automatic wait_points(input int n);
        int c;
        c = 0;
        while (q.size() < n && c < 5000) begin
            @(negedge clk);
            c++;
        end
    endtask

    initial begin
        int   bad_valid;
        int   bad_stable;
        logic [9:0] hx;
        logic [9:0] hy;
        pt_t  exp2[4];

        // Reset values
        repeat (3) @(negedge clk);
        check_eq("rst_valid", 32'(out_valid), 32'd0);
        check_eq("rst_x", 32'(out_x), 32'd0);
        check_eq("rst_y", 32'(out_y), 32'd0);
        check_eq("rst_busy", 32'(busy), 32'd0);
        reset = 1'b1;

        // First sample: single point
        send(10, 10, 1'b1);
        wait_idle("first");
        check_eq("first_n", q.size(), 32'd1);
        check_eq("first_pt", 32'(q_at(0)), 32'(pt(10, 10)));

        // (10,10) -> (14,12)
        q.delete();
        exp2[0] = pt(11, 11);
        exp2[1] = pt(12, 11);
        exp2[2] = pt(13, 12);
        exp2[3] = pt(14, 12);
        send(14, 12, 1'b1);
        wait_idle("line1");
        check_eq("line1_n", q.size(), 32'd4);
        for (int i = 0; i < 4; i++) check_eq("line1_pt", 32'(q_at(i)), 32'(exp2[i]));

        // (14,12) -> (639,479): 625 points
        q.delete();
        send(639, 479, 1'b1);
        wait_idle("long");
        check_eq("long_n", q.size(), 32'd625);
        check_eq("long_last", 32'(q_at(624)), 32'(pt(639, 479)));

        // Clipped to the same point: nothing emitted
        q.delete();
        send(700, 600, 1'b1);
        wait_idle("clip");
        check_eq("clip_n", q.size(), 32'd0);

        // Pen-up then a new first point
        send(0, 0, 1'b0);
        wait_idle("penup");
        check_eq("penup_n", q.size(), 32'd0);
        send(5, 5, 1'b1);
        wait_idle("restart");
        check_eq("restart_n", q.size(), 32'd1);
        check_eq("restart_pt", 32'(q_at(0)), 32'(pt(5, 5)));

        // Backpressure during (5,5) -> (15,5)
        q.delete();
        send(15, 5, 1'b1);
        wait_points(3);
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        repeat (2) @(negedge clk);
        hx = out_x;
        hy = out_y;
        bad_valid = 0;
        bad_stable = 0;
        repeat (20) begin
            @(negedge clk);
            if (!out_valid) bad_valid++;
            if (out_x != hx || out_y != hy) bad_stable++;
        end
        check_eq("bp_valid_drop", 32'(bad_valid), 32'd0);
        check_eq("bp_coord_change", 32'(bad_stable), 32'd0);
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        wait_idle("bp");
        check_eq("bp_n", q.size(), 32'd10);
        for (int i = 0; i < 10; i++) check_eq("bp_pt", 32'(q_at(i)), 32'(pt(6 + i, 5)));

        // A=(200,5) runs, B overwritten by C, then A -> C
        q.delete();
        send(200, 5, 1'b1);
        repeat (10) @(posedge clk);
        send(20, 20, 1'b1);
        repeat (5) @(posedge clk);
        send(15, 30, 1'b1);
        wait_idle("drop");
        check_eq("drop_n", q.size(), 32'd370);
        check_eq("drop_a_end", 32'(q_at(184)), 32'(pt(200, 5)));
        check_eq("drop_c_first", 32'(q_at(185)), 32'(pt(199, 5)));
        check_eq("drop_c_end", 32'(q_at(369)), 32'(pt(15, 30)));
`ifdef LINE_INTERP_STATS_EN
        check_eq("drop_count", 32'(drop_count), 32'd1);
        check_eq("point_count", 32'(point_count), 32'(n_xfer[15:0]));
`endif

        // Reset mid-line (0,0) -> (100,0) after 30 points
        send(0, 0, 1'b0);
        wait_idle("rl_penup");
        q.delete();
        send(0, 0, 1'b1);
        wait_idle("rl_start");
        check_eq("rl_start_pt", 32'(q_at(0)), 32'(pt(0, 0)));
        q.delete();
        send(100, 0, 1'b1);
        wait_points(30);
        check_eq("rl_reached30", 32'(q.size() >= 30), 32'd1);
        #2;
        reset = 1'b0;
        #1;
        check_eq("rl_valid", 32'(out_valid), 32'd0);
        check_eq("rl_x", 32'(out_x), 32'd0);
        check_eq("rl_y", 32'(out_y), 32'd0);
        check_eq("rl_busy", 32'(busy), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        q.delete();
        send(50, 50, 1'b1);
        wait_idle("after_rst");
        check_eq("after_rst_n", q.size(), 32'd1);
        check_eq("after_rst_pt", 32'(q_at(0)), 32'(pt(50, 50)));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
